// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - two-mode VGA timing generator with frame-aligned mode switch
// and a configurable output delay line for sync/blank/strobe signals.
module vga_timing_gen #(
  parameter int   X_W        = 11,
  parameter int   Y_W        = 10,
  parameter int   M0_H_DISP  = 800,
  parameter int   M0_H_FP    = 56,
  parameter int   M0_H_SYNC  = 120,
  parameter int   M0_H_BP    = 64,
  parameter int   M0_V_DISP  = 600,
  parameter int   M0_V_FP    = 37,
  parameter int   M0_V_SYNC  = 6,
  parameter int   M0_V_BP    = 23,
  parameter int   M1_H_DISP  = 640,
  parameter int   M1_H_FP    = 16,
  parameter int   M1_H_SYNC  = 96,
  parameter int   M1_H_BP    = 48,
  parameter int   M1_V_DISP  = 480,
  parameter int   M1_V_FP    = 10,
  parameter int   M1_V_SYNC  = 2,
  parameter int   M1_V_BP    = 33,
  parameter logic M0_HPOL    = 1'b1,
  parameter logic M0_VPOL    = 1'b1,
  parameter logic M1_HPOL    = 1'b0,
  parameter logic M1_VPOL    = 1'b0,
  parameter int   PIPE_DELAY = 0
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Enable,
  input  logic           ModeSel,
  output logic           ActiveMode,
  output logic           hSync,
  output logic           vSync,
  output logic           sync_n,
  output logic           blank_n,
  output logic [X_W-1:0] nextX,
  output logic [Y_W-1:0] nextY,
  output logic           lineStart,
  output logic           frameStart
);

  localparam int M0_HTOT = M0_H_DISP + M0_H_FP + M0_H_SYNC + M0_H_BP;
  localparam int M0_VTOT = M0_V_DISP + M0_V_FP + M0_V_SYNC + M0_V_BP;
  localparam int M1_HTOT = M1_H_DISP + M1_H_FP + M1_H_SYNC + M1_H_BP;
  localparam int M1_VTOT = M1_V_DISP + M1_V_FP + M1_V_SYNC + M1_V_BP;

  if (M0_HTOT > (2 ** X_W) || M1_HTOT > (2 ** X_W)) begin : g_bad_htot
    $error("vga_timing_gen: horizontal total exceeds 2**X_W");
  end
  if (M0_VTOT > (2 ** Y_W) || M1_VTOT > (2 ** Y_W)) begin : g_bad_vtot
    $error("vga_timing_gen: vertical total exceeds 2**Y_W");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_DELAY outside 0..7");
  end

  // Boundaries carry one extra bit so a sync end equal to 2**X_W still compares correctly.
  localparam logic [X_W:0] M0_HDE   = (X_W+1)'(M0_H_DISP);
  localparam logic [X_W:0] M0_HSS   = (X_W+1)'(M0_H_DISP + M0_H_FP);
  localparam logic [X_W:0] M0_HSE   = (X_W+1)'(M0_H_DISP + M0_H_FP + M0_H_SYNC);
  localparam logic [X_W:0] M0_HLAST = (X_W+1)'(M0_HTOT - 1);
  localparam logic [X_W:0] M1_HDE   = (X_W+1)'(M1_H_DISP);
  localparam logic [X_W:0] M1_HSS   = (X_W+1)'(M1_H_DISP + M1_H_FP);
  localparam logic [X_W:0] M1_HSE   = (X_W+1)'(M1_H_DISP + M1_H_FP + M1_H_SYNC);
  localparam logic [X_W:0] M1_HLAST = (X_W+1)'(M1_HTOT - 1);
  localparam logic [Y_W:0] M0_VDE   = (Y_W+1)'(M0_V_DISP);
  localparam logic [Y_W:0] M0_VSS   = (Y_W+1)'(M0_V_DISP + M0_V_FP);
  localparam logic [Y_W:0] M0_VSE   = (Y_W+1)'(M0_V_DISP + M0_V_FP + M0_V_SYNC);
  localparam logic [Y_W:0] M0_VLAST = (Y_W+1)'(M0_VTOT - 1);
  localparam logic [Y_W:0] M1_VDE   = (Y_W+1)'(M1_V_DISP);
  localparam logic [Y_W:0] M1_VSS   = (Y_W+1)'(M1_V_DISP + M1_V_FP);
  localparam logic [Y_W:0] M1_VSE   = (Y_W+1)'(M1_V_DISP + M1_V_FP + M1_V_SYNC);
  localparam logic [Y_W:0] M1_VLAST = (Y_W+1)'(M1_VTOT - 1);
  localparam logic [X_W-1:0] H_ONE  = X_W'(1);
  localparam logic [Y_W-1:0] V_ONE  = Y_W'(1);

  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_W-1:0] v_cnt_q, v_cnt_d;
  logic           mode_q, mode_d;

  logic [X_W:0] h_ext, h_de, h_ss, h_se, h_last;
  logic [Y_W:0] v_ext, v_de, v_ss, v_se, v_last;
  logic         hpol, vpol;
  logic         h_wrap, v_wrap;
  logic         h_disp, v_disp, hs_act, vs_act;
  logic [5:0]   raw_vec, out_vec;

  assign h_de   = mode_q ? M1_HDE   : M0_HDE;
  assign h_ss   = mode_q ? M1_HSS   : M0_HSS;
  assign h_se   = mode_q ? M1_HSE   : M0_HSE;
  assign h_last = mode_q ? M1_HLAST : M0_HLAST;
  assign v_de   = mode_q ? M1_VDE   : M0_VDE;
  assign v_ss   = mode_q ? M1_VSS   : M0_VSS;
  assign v_se   = mode_q ? M1_VSE   : M0_VSE;
  assign v_last = mode_q ? M1_VLAST : M0_VLAST;
  assign hpol   = mode_q ? M1_HPOL  : M0_HPOL;
  assign vpol   = mode_q ? M1_VPOL  : M0_VPOL;

  assign h_ext  = {1'b0, h_cnt_q};
  assign v_ext  = {1'b0, v_cnt_q};
  assign h_wrap = (h_ext == h_last);
  assign v_wrap = (v_ext == v_last);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    mode_d  = mode_q;
    if (Enable) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        if (v_wrap) begin
          v_cnt_d = '0;
          // Mode only changes at the frame boundary, so no line or frame is ever cut short.
          mode_d  = ModeSel;
        end else begin
          v_cnt_d = v_cnt_q + V_ONE;
        end
      end else begin
        h_cnt_d = h_cnt_q + H_ONE;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign h_disp = (h_ext < h_de);
  assign v_disp = (v_ext < v_de);
  assign hs_act = (h_ext >= h_ss) && (h_ext < h_se);
  assign vs_act = (v_ext >= v_ss) && (v_ext < v_se);

  // Packed as {hSync, vSync, sync_n, blank_n, lineStart, frameStart}.
  always_comb begin
    raw_vec    = '0;
    raw_vec[5] = hs_act ? hpol : ~hpol;
    raw_vec[4] = vs_act ? vpol : ~vpol;
    raw_vec[3] = ~(hs_act | vs_act);
    raw_vec[2] = h_disp && v_disp;
    raw_vec[1] = Enable && (h_cnt_q == '0);
    raw_vec[0] = Enable && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  if (PIPE_DELAY == 0) begin : g_nopipe
    assign out_vec = raw_vec;
  end else begin : g_pipe
    localparam logic [5:0] RST_VEC = {~M0_HPOL, ~M0_VPOL, 1'b1, 3'b000};
    logic [5:0] pipe_q [PIPE_DELAY];
    logic [5:0] pipe_d [PIPE_DELAY];

    always_comb begin
      pipe_d[0] = raw_vec;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    // The delay line shifts even while Enable is low, keeping a fixed output latency.
    always_ff @(posedge Clock) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        if (Reset) begin
          pipe_q[i] <= RST_VEC;
        end else begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end

    assign out_vec = pipe_q[PIPE_DELAY-1];
  end

  assign hSync      = out_vec[5];
  assign vSync      = out_vec[4];
  assign sync_n     = out_vec[3];
  assign blank_n    = out_vec[2];
  assign lineStart  = out_vec[1];
  assign frameStart = out_vec[0];
  assign ActiveMode = mode_q;
  assign nextX      = h_disp ? h_cnt_q : '0;
  assign nextY      = v_disp ? v_cnt_q : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: default-timing instance for line behaviour,
// small-timing instance (PIPE_DELAY=2) for frame, mode-switch and delay behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, ms_a;
  logic am_a, hs_a, vs_a, sn_a, bn_a, ls_a, fs_a;
  logic [10:0] nx_a;
  logic [9:0]  ny_a;

  logic rst_b, en_b, ms_b;
  logic am_b, hs_b, vs_b, sn_b, bn_b, ls_b, fs_b;
  logic [4:0] nx_b;
  logic [3:0] ny_b;

  int checks   = 0;
  int failures = 0;

  vga_timing_gen dut_a (
    .Clock(clk), .Reset(rst_a), .Enable(en_a), .ModeSel(ms_a),
    .ActiveMode(am_a), .hSync(hs_a), .vSync(vs_a), .sync_n(sn_a), .blank_n(bn_a),
    .nextX(nx_a), .nextY(ny_a), .lineStart(ls_a), .frameStart(fs_a)
  );

  // Mode 0: 8/2/3/2 x 6/1/2/1 (15x10), mode 1: 6/2/2/2 x 4/1/1/2 (12x8).
  vga_timing_gen #(
    .X_W(5), .Y_W(4),
    .M0_H_DISP(8), .M0_H_FP(2), .M0_H_SYNC(3), .M0_H_BP(2),
    .M0_V_DISP(6), .M0_V_FP(1), .M0_V_SYNC(2), .M0_V_BP(1),
    .M1_H_DISP(6), .M1_H_FP(2), .M1_H_SYNC(2), .M1_H_BP(2),
    .M1_V_DISP(4), .M1_V_FP(1), .M1_V_SYNC(1), .M1_V_BP(2),
    .PIPE_DELAY(2)
  ) dut_b (
    .Clock(clk), .Reset(rst_b), .Enable(en_b), .ModeSel(ms_b),
    .ActiveMode(am_b), .hSync(hs_b), .vSync(vs_b), .sync_n(sn_b), .blank_n(bn_b),
    .nextX(nx_b), .nextY(ny_b), .lineStart(ls_b), .frameStart(fs_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int n, hs_first, hs_cnt, ls_seen;
    int vs_first, vs_cnt, fs_cnt, snl_cnt, bn_cnt;

    rst_a = 1'b1; en_a = 1'b1; ms_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b1; ms_b = 1'b0;
    tick();
    tick();

    chk("a_rst_x", 32'(nx_a), 0);
    chk("a_rst_y", 32'(ny_a), 0);
    chk("a_rst_mode", 32'(am_a), 0);
    chk("b_rst_blank", 32'(bn_b), 0);
    chk("b_rst_syncn", 32'(sn_b), 1);
    chk("b_rst_hs", 32'(hs_b), 0);
    chk("b_rst_vs", 32'(vs_b), 0);
    chk("b_rst_ls", 32'(ls_b), 0);
    chk("b_rst_fs", 32'(fs_b), 0);

    rst_a = 1'b0;
    chk("a_start_ls", 32'(ls_a), 1);
    chk("a_start_fs", 32'(fs_a), 1);
    chk("a_start_blank", 32'(bn_a), 1);
    chk("a_start_hs", 32'(hs_a), 0);
    chk("a_start_syncn", 32'(sn_a), 1);

    n = 0; hs_first = -1; hs_cnt = 0;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (hs_a) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (ls_a) begin
        n = i;
        break;
      end
    end
    chk("a_line_period", n, 1040);
    chk("a_hs_first", hs_first, 856);
    chk("a_hs_width", hs_cnt, 120);
    chk("a_line1_y", 32'(ny_a), 1);

    repeat (799) tick();
    chk("a_x799", 32'(nx_a), 799);
    chk("a_blank799", 32'(bn_a), 1);

    en_a = 1'b0;
    ls_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("a_hold_x", 32'(nx_a), 799);
      if (ls_a) ls_seen++;
    end
    chk("a_hold_nols", ls_seen, 0);

    en_a = 1'b1;
    tick();
    chk("a_resume_x", 32'(nx_a), 0);
    chk("a_resume_blank", 32'(bn_a), 0);
    chk("a_resume_y", 32'(ny_a), 1);

    n = 0;
    for (int i = 1; i <= 500; i++) begin
      tick();
      if (ls_a) begin
        n = i;
        break;
      end
    end
    chk("a_resume_rest", n, 240);

    repeat (300) tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("a_midrst_x", 32'(nx_a), 0);
    chk("a_midrst_y", 32'(ny_a), 0);
    chk("a_midrst_mode", 32'(am_a), 0);
    chk("a_midrst_blank", 32'(bn_a), 1);
    chk("a_midrst_fs", 32'(fs_a), 1);

    rst_b = 1'b0;
    chk("b_c0_x", 32'(nx_b), 0);
    chk("b_c0_blank", 32'(bn_b), 0);
    chk("b_c0_fs", 32'(fs_b), 0);

    vs_first = -1; vs_cnt = 0; fs_cnt = 0; snl_cnt = 0; bn_cnt = 0;
    for (int c = 1; c <= 152; c++) begin
      tick();
      if (vs_b) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
      end
      if (fs_b) fs_cnt++;
      if (!sn_b) snl_cnt++;
      if (bn_b) bn_cnt++;
      if (c == 1)  chk("b_c1_blank", 32'(bn_b), 0);
      if (c == 2) begin
        chk("b_c2_blank", 32'(bn_b), 1);
        chk("b_c2_fs", 32'(fs_b), 1);
        chk("b_c2_ls", 32'(ls_b), 1);
      end
      if (c == 11) chk("b_hs_c11", 32'(hs_b), 0);
      if (c == 12) chk("b_hs_c12", 32'(hs_b), 1);
      if (c == 14) chk("b_hs_c14", 32'(hs_b), 1);
      if (c == 15) chk("b_hs_c15", 32'(hs_b), 0);
      if (c == 82) begin
        chk("b_lastpix_x", 32'(nx_b), 7);
        chk("b_lastpix_y", 32'(ny_b), 5);
      end
      if (c == 83) begin
        chk("b_afterpix_x", 32'(nx_b), 0);
        chk("b_afterpix_y", 32'(ny_b), 5);
      end
      if (c == 84) chk("b_lastpix_blank", 32'(bn_b), 1);
      if (c == 85) chk("b_afterpix_blank", 32'(bn_b), 0);
      if (c == 152) chk("b_frame_period", 32'(fs_b), 1);
    end
    chk("b_vs_first", vs_first, 107);
    chk("b_vs_width", vs_cnt, 30);
    chk("b_fs_count", fs_cnt, 2);
    chk("b_syncn_low", snl_cnt, 54);
    chk("b_blank_high", bn_cnt, 49);

    ms_b = 1'b1;
    for (int c = 153; c <= 312; c++) begin
      tick();
      if (c == 200) chk("b_mid_mode", 32'(am_b), 0);
      if (c == 299) chk("b_old_last_mode", 32'(am_b), 0);
      if (c == 300) begin
        chk("b_new_mode", 32'(am_b), 1);
        chk("b_new_x", 32'(nx_b), 0);
        chk("b_new_y", 32'(ny_b), 0);
      end
      if (c == 301) chk("b_hs_c301", 32'(hs_b), 0);
      if (c == 302) begin
        chk("b_hs_c302", 32'(hs_b), 1);
        chk("b_new_fs", 32'(fs_b), 1);
      end
      if (c == 305) chk("b_m1_x5", 32'(nx_b), 5);
      if (c == 306) chk("b_m1_x6", 32'(nx_b), 0);
      if (c == 309) chk("b_hs_c309", 32'(hs_b), 1);
      if (c == 310) chk("b_hs_c310", 32'(hs_b), 0);
      if (c == 311) begin
        chk("b_hs_c311", 32'(hs_b), 0);
        chk("b_m1_y_c311", 32'(ny_b), 0);
      end
      if (c == 312) begin
        chk("b_hs_c312", 32'(hs_b), 1);
        chk("b_m1_y_c312", 32'(ny_b), 1);
      end
    end

    repeat (6) tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("b_midrst_x", 32'(nx_b), 0);
    chk("b_midrst_y", 32'(ny_b), 0);
    chk("b_midrst_mode", 32'(am_b), 0);
    chk("b_midrst_blank", 32'(bn_b), 0);
    tick();
    tick();
    chk("b_midrst_blank2", 32'(bn_b), 1);
    chk("b_midrst_fs2", 32'(fs_b), 1);
    chk("b_midrst_mode2", 32'(am_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
